tag_allocator: RTL



---
 rtl/tag_alloc_pkg.sv | 22 ++
 rtl/tag_alloc_fifo.sv | 68 ++++++
 rtl/tag_allocator.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tag_alloc_pkg.sv
// ============================================================================
// Module      : tag_alloc_pkg
// Description : Shared types and helpers for the tag allocator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tag_alloc_pkg;

  typedef enum logic {
    ALLOC_LOWEST = 1'b0,
    ALLOC_FIFO   = 1'b1
  } alloc_mode_e;

  // Circular-buffer index wrap; depth is always an elaboration constant.
  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned depth);
    return idx % depth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tag_alloc_fifo.sv
// ============================================================================
// Module      : tag_alloc_fifo
// Description : Circular free list with multi-pop / multi-push per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_alloc_fifo import tag_alloc_pkg::*; #(
  parameter  int unsigned NumTags      = 8,
  parameter  int unsigned NumGetPorts  = 2,
  parameter  int unsigned NumFreePorts = 2,
  localparam int unsigned TagWidth     = $clog2(NumTags),
  localparam int unsigned PopWidth     = $clog2(NumGetPorts + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic [PopWidth-1:0]                    pop_cnt_i,
  input  logic [NumFreePorts-1:0]                push_i,
  input  logic [NumFreePorts-1:0][TagWidth-1:0]  push_tag_i,
  output logic [NumGetPorts-1:0][TagWidth-1:0]   head_tags_o
);

  localparam type tag_t = logic [TagWidth-1:0];

  tag_t mem_q [NumTags];
  tag_t mem_d [NumTags];
  tag_t head_q, head_d;
  tag_t tail_q, tail_d;

  always_comb begin
    int unsigned wr;
    wr     = 0;
    mem_d  = mem_q;
    // Same-cycle pushes land in ascending port order.
    for (int m = 0; m < NumFreePorts; m++) begin
      if (push_i[m]) begin
        mem_d[tag_t'(wrap_idx(32'(tail_q) + wr, NumTags))] = push_tag_i[m];
        wr = wr + 1;
      end
    end
    tail_d = tag_t'(wrap_idx(32'(tail_q) + wr, NumTags));
    head_d = tag_t'(wrap_idx(32'(head_q) + 32'(pop_cnt_i), NumTags));
  end

  always_comb begin
    for (int j = 0; j < NumGetPorts; j++) begin
      head_tags_o[j] = mem_q[tag_t'(wrap_idx(32'(head_q) + 32'(j), NumTags))];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int i = 0; i < NumTags; i++) begin
        mem_q[i] <= tag_t'(i);
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tag_allocator.sv
// ============================================================================
// Module      : tag_allocator
// Description : Multi-port tag allocator (lowest-index or FIFO order).
//               Define TAG_ALLOC_CHECK_EN to reject illegal releases and
//               flag them on err_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_allocator import tag_alloc_pkg::*; #(
  parameter  int unsigned NumTags      = 8,
  parameter  int unsigned NumGetPorts  = 2,
  parameter  int unsigned NumFreePorts = 2,
  parameter  alloc_mode_e AllocMode    = ALLOC_LOWEST,
  localparam int unsigned TagWidth     = $clog2(NumTags),
  localparam int unsigned CntWidth     = $clog2(NumTags + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic [NumFreePorts-1:0]                free_i,
  input  logic [NumFreePorts-1:0][TagWidth-1:0]  tag_i,
  input  logic [NumGetPorts-1:0]                 get_i,
  output logic [NumGetPorts-1:0]                 valid_o,
  output logic [NumGetPorts-1:0][TagWidth-1:0]   tag_o,
  output logic [CntWidth-1:0]                    count_o,
  output logic                                   err_o
);

  localparam type tag_t = logic [TagWidth-1:0];
  localparam int unsigned PopWidth = $clog2(NumGetPorts + 1);
  localparam int unsigned RelWidth = $clog2(NumFreePorts + 1);

  logic [NumTags-1:0]                  used_q, used_d;
  logic [CntWidth-1:0]                 count_q, count_d;
  logic [NumGetPorts-1:0][PopWidth-1:0] rank;
  logic [NumGetPorts-1:0]              grant;
  logic [PopWidth-1:0]                 n_grant;
  logic [RelWidth-1:0]                 n_rel;
  logic [NumFreePorts-1:0]             rel_ok;
  logic                                grant_dup;

  // Port k offers the r(k)-th free tag, r(k) = requests on lower ports.
  always_comb begin
    logic [PopWidth-1:0] acc;
    acc     = '0;
    n_grant = '0;
    for (int k = 0; k < NumGetPorts; k++) begin
      rank[k]    = acc;
      acc        = acc + PopWidth'(get_i[k]);
      valid_o[k] = (count_q > CntWidth'(rank[k])) && !flush_i;
      grant[k]   = get_i[k] && valid_o[k];
      n_grant    = n_grant + PopWidth'(grant[k]);
    end
  end

  if (AllocMode == ALLOC_FIFO) begin : g_fifo
    logic [NumGetPorts-1:0][TagWidth-1:0] head_tags;

    tag_alloc_fifo #(
      .NumTags      (NumTags),
      .NumGetPorts  (NumGetPorts),
      .NumFreePorts (NumFreePorts)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .pop_cnt_i   (n_grant),
      .push_i      (rel_ok),
      .push_tag_i  (tag_i),
      .head_tags_o (head_tags)
    );

    always_comb begin
      for (int k = 0; k < NumGetPorts; k++) begin
        tag_o[k] = head_tags[rank[k]];
      end
    end
  end else begin : g_lowest
    always_comb begin
      int unsigned seen;
      for (int k = 0; k < NumGetPorts; k++) begin
        seen     = 0;
        tag_o[k] = '0;
        for (int t = 0; t < NumTags; t++) begin
          if (!used_q[t]) begin
            if (seen == 32'(rank[k])) tag_o[k] = tag_t'(t);
            seen = seen + 1;
          end
        end
      end
    end
  end

`ifdef TAG_ALLOC_CHECK_EN
  logic err_q, err_d;

  // A release is dropped if the tag is not held or appears on another port.
  always_comb begin
    err_d  = err_q;
    rel_ok = '0;
    for (int m = 0; m < NumFreePorts; m++) begin
      rel_ok[m] = free_i[m] && (32'(tag_i[m]) < NumTags) && used_q[tag_i[m]];
      for (int n = 0; n < NumFreePorts; n++) begin
        if (n != m && free_i[n] && tag_i[n] == tag_i[m]) rel_ok[m] = 1'b0;
      end
      if (free_i[m] && !rel_ok[m]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) err_q <= 1'b0;
    else                    err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign rel_ok = free_i;
  assign err_o  = 1'b0;
`endif

  always_comb begin
    used_d = used_q;
    n_rel  = '0;
    for (int k = 0; k < NumGetPorts; k++) begin
      if (grant[k]) used_d[tag_o[k]] = 1'b1;
    end
    for (int m = 0; m < NumFreePorts; m++) begin
      if (rel_ok[m]) begin
        used_d[tag_i[m]] = 1'b0;
        n_rel            = n_rel + RelWidth'(1);
      end
    end
    count_d = count_q - CntWidth'(n_grant) + CntWidth'(n_rel);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      used_q  <= '0;
      count_q <= CntWidth'(NumTags);
    end else begin
      used_q  <= used_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

  always_comb begin
    grant_dup = 1'b0;
    for (int k = 0; k < NumGetPorts; k++) begin
      for (int j = k + 1; j < NumGetPorts; j++) begin
        if (grant[k] && grant[j] && tag_o[k] == tag_o[j]) grant_dup = 1'b1;
      end
    end
  end

  a_grant_distinct: assert property (@(posedge clk_i) disable iff (!rst_ni) !grant_dup);
  a_count_matches:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     count_q == CntWidth'(NumTags - $countones(used_q)));

endmodule

`default_nettype wire
